// File: rtl/stage_link.sv
// Pipeline link between two match-action stages: buffers PHV and VLAN words in
// independent skid FIFOs and forwards the control AXI-Stream through a register slice.

module stage_link_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int SKID  = 3
) (
  input  logic             axis_clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - SKID - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;
  logic             drop;

  // Upstream does not wait for ready, so a word arriving while full is lost and counted.
  always_comb begin
    push       = in_valid && (count < FULL);
    drop       = in_valid && (count == FULL);
    pop        = (count != '0) && out_ready;
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Ready is registered from the next count so it tracks the count register exactly.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf_cnt   <= 8'd0;
    end else begin
      count     <= count_next;
      ready     <= (count_next <= READY_MAX);
      out_valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_data <= mem[rd_ptr];
      end
      if (drop && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end

endmodule

module stage_link #(
  parameter int PHV_LEN              = 48*8 + 32*8 + 16*8 + 256,
  parameter int C_VLANID_WIDTH       = 12,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH           = 8,
  parameter int SKID                 = 3
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_in_valid,
  output logic                              ready_out,
  input  logic [C_VLANID_WIDTH-1:0]         vlan_in,
  input  logic                              vlan_valid_in,
  output logic                              vlan_ready_out,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              ready_in,
  output logic [C_VLANID_WIDTH-1:0]         vlan_out,
  output logic                              vlan_valid_out,
  input  logic                              vlan_ready_in,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic [7:0]                        phv_ovf_cnt,
  output logic [7:0]                        vlan_ovf_cnt
);

  stage_link_fifo #(
    .WIDTH (PHV_LEN),
    .DEPTH (FIFO_DEPTH),
    .SKID  (SKID)
  ) u_phv_fifo (
    .axis_clk  (axis_clk),
    .aresetn   (aresetn),
    .in_data   (phv_in),
    .in_valid  (phv_in_valid),
    .ready     (ready_out),
    .out_data  (phv_out),
    .out_valid (phv_out_valid),
    .out_ready (ready_in),
    .ovf_cnt   (phv_ovf_cnt)
  );

  stage_link_fifo #(
    .WIDTH (C_VLANID_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .SKID  (SKID)
  ) u_vlan_fifo (
    .axis_clk  (axis_clk),
    .aresetn   (aresetn),
    .in_data   (vlan_in),
    .in_valid  (vlan_valid_in),
    .ready     (vlan_ready_out),
    .out_data  (vlan_out),
    .out_valid (vlan_valid_out),
    .out_ready (vlan_ready_in),
    .ovf_cnt   (vlan_ovf_cnt)
  );

  // Control stream is never back-pressured; a plain one-cycle slice suffices.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tdata  <= c_s_axis_tdata;
      c_m_axis_tuser  <= c_s_axis_tuser;
      c_m_axis_tkeep  <= c_s_axis_tkeep;
      c_m_axis_tvalid <= c_s_axis_tvalid;
      c_m_axis_tlast  <= c_s_axis_tlast;
    end
  end

endmodule
